nios_system_sysid_checker: RTL and testbench

Boot-time integrity checker for the system ID peripheral. An Avalon-MM read master reads the system ID word (address 0) and the build timestamp word (address 1), compares them against values fixed at elaboration, and reports pass/mismatch/timeout status to the reset sequencer and LED debug logic. It sits between the reset controller and the sysid slave on the same interconnect; the visualizer datapath is held off until `pass` is seen.

---
 rtl/nios_system_sysid_pkg.sv | 26 ++
 rtl/nios_system_sysid_rd_xact.sv | 71 +++++++
 rtl/nios_system_sysid_checker.sv | 178 +++++++++++++++++
 tb/tb_nios_system_sysid_checker.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/nios_system_sysid_pkg.sv
// Shared constants and state encoding for the sysid boot-time checker.
package nios_system_sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ID_REQ,
        ST_ID_WAIT,
        ST_TS_REQ,
        ST_TS_WAIT,
        ST_EVAL,
        ST_DONE
    } state_e;

    localparam logic        SYSID_ADDR_ID       = 1'b0;
    localparam logic        SYSID_ADDR_TS       = 1'b1;
    localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'h556C8EB9;

    function automatic logic is_req(input state_e s);
        return (s == ST_ID_REQ) || (s == ST_TS_REQ);
    endfunction

    function automatic logic is_wait(input state_e s);
        return (s == ST_ID_WAIT) || (s == ST_TS_WAIT);
    endfunction

endpackage

// File: rtl/nios_system_sysid_rd_xact.sv
// One Avalon-MM read transaction: registered strobe/address, per-attempt
// timeout counter and a retry budget shared across the whole check.
module nios_system_sysid_rd_xact
    import nios_system_sysid_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRIES    = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_launch,
    input  logic        i_req,
    input  logic        i_wait,
    input  logic        i_next_req,
    input  logic        i_next_addr,
    input  logic        i_waitrequest,
    input  logic        i_readdatavalid,
    input  logic [31:0] i_readdata,
    output logic        o_read,
    output logic        o_address,
    output logic        o_accept,
    output logic        o_ok,
    output logic        o_retry,
    output logic        o_fail,
    output logic [31:0] o_data
);

    localparam logic [15:0] TC_LAST   = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

    logic [15:0] r_tcnt;
    logic [3:0]  r_retries;
    logic        r_read;
    logic        r_addr;
    logic        w_active;
    logic        w_expire;

    assign w_active = i_req | i_wait;
    assign o_accept = i_req & ~i_waitrequest;
    assign o_ok     = i_wait & i_readdatavalid;
    // Data arriving on the expiry cycle wins over the timeout.
    assign w_expire = w_active & ~o_ok & (r_tcnt == TC_LAST);
    assign o_retry  = w_expire & (r_retries < RETRY_MAX);
    assign o_fail   = w_expire & ~o_retry;
    assign o_data   = i_readdata;

    assign o_read    = r_read;
    assign o_address = r_addr;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tcnt    <= '0;
            r_retries <= '0;
            r_read    <= 1'b0;
            r_addr    <= SYSID_ADDR_ID;
        end else begin
            r_read <= i_next_req;
            r_addr <= i_next_addr;
            if (i_launch)
                r_tcnt <= '0;
            else if (w_active)
                r_tcnt <= r_tcnt + 16'd1;
            if (i_clear)
                r_retries <= '0;
            else if (o_retry)
                r_retries <= r_retries + 4'd1;
        end
    end

endmodule

// File: rtl/nios_system_sysid_checker.sv
// Boot-time sysid integrity checker: reads ID and timestamp words over
// Avalon-MM, compares them with elaboration-time values, reports status.
module nios_system_sysid_checker
    import nios_system_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h0,
    parameter int          CHECK_TIMESTAMP    = 1,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter int          MAX_RETRIES        = 3,
    parameter int          AUTO_START         = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] read_id,
    output logic [31:0] read_ts,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid
);

    state_e      r_state;
    state_e      w_next;
    logic        r_auto;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic        r_idm;
    logic        r_tsm;
    logic        r_to;
    logic [31:0] r_read_id;
    logic [31:0] r_read_ts;

    logic        w_launch;
    logic        w_clear;
    logic        w_accept;
    logic        w_ok;
    logic        w_retry;
    logic        w_fail;
    logic [31:0] w_data;
    logic        w_next_req;
    logic        w_next_addr;
    logic        w_idm;
    logic        w_tsm;

    assign w_next_req  = is_req(w_next);
    assign w_next_addr = (w_next == ST_TS_REQ) || (w_next == ST_TS_WAIT);

    nios_system_sysid_rd_xact #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES)
    ) u_xact (
        .clock          (clock),
        .reset          (reset),
        .i_clear        (w_clear),
        .i_launch       (w_launch),
        .i_req          (is_req(r_state)),
        .i_wait         (is_wait(r_state)),
        .i_next_req     (w_next_req),
        .i_next_addr    (w_next_addr),
        .i_waitrequest  (avm_waitrequest),
        .i_readdatavalid(avm_readdatavalid),
        .i_readdata     (avm_readdata),
        .o_read         (avm_read),
        .o_address      (avm_address),
        .o_accept       (w_accept),
        .o_ok           (w_ok),
        .o_retry        (w_retry),
        .o_fail         (w_fail),
        .o_data         (w_data)
    );

    always_comb begin
        w_next   = r_state;
        w_launch = 1'b0;
        w_clear  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start || r_auto) begin
                    w_next   = ST_ID_REQ;
                    w_launch = 1'b1;
                    w_clear  = 1'b1;
                end
            end
            ST_ID_REQ, ST_TS_REQ: begin
                if (w_retry)
                    w_launch = 1'b1;
                else if (w_fail)
                    w_next = ST_DONE;
                else if (w_accept)
                    w_next = (r_state == ST_ID_REQ) ? ST_ID_WAIT : ST_TS_WAIT;
            end
            ST_ID_WAIT: begin
                if (w_ok) begin
                    w_next   = ST_TS_REQ;
                    w_launch = 1'b1;
                end else if (w_retry) begin
                    w_next   = ST_ID_REQ;
                    w_launch = 1'b1;
                end else if (w_fail) begin
                    w_next = ST_DONE;
                end
            end
            ST_TS_WAIT: begin
                if (w_ok) begin
                    w_next = ST_EVAL;
                end else if (w_retry) begin
                    w_next   = ST_TS_REQ;
                    w_launch = 1'b1;
                end else if (w_fail) begin
                    w_next = ST_DONE;
                end
            end
            ST_EVAL: w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_idm = (r_read_id != EXPECTED_ID);
    assign w_tsm = (r_read_ts != EXPECTED_TIMESTAMP);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_auto    <= (AUTO_START != 0);
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_idm     <= 1'b0;
            r_tsm     <= 1'b0;
            r_to      <= 1'b0;
            r_read_id <= '0;
            r_read_ts <= '0;
        end else begin
            r_state <= w_next;
            r_auto  <= 1'b0;
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (w_next == ST_DONE);
            if (w_clear) begin
                r_pass <= 1'b0;
                r_idm  <= 1'b0;
                r_tsm  <= 1'b0;
                r_to   <= 1'b0;
            end
            if (r_state == ST_ID_WAIT && w_ok)
                r_read_id <= w_data;
            if (r_state == ST_TS_WAIT && w_ok)
                r_read_ts <= w_data;
            if (w_fail)
                r_to <= 1'b1;
            if (r_state == ST_EVAL) begin
                r_idm  <= w_idm;
                r_tsm  <= w_tsm;
                r_pass <= !w_idm && !((CHECK_TIMESTAMP != 0) && w_tsm);
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign id_mismatch = r_idm;
    assign ts_mismatch = r_tsm;
    assign timeout     = r_to;
    assign read_id     = r_read_id;
    assign read_ts     = r_read_ts;

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// Directed bench: two checker instances (timestamp enforced / report-only)
// behind one behavioural sysid slave with stall, no-response and stray-valid knobs.
module tb_nios_system_sysid_checker;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, start, start2;
    logic busy1, done1, pass1, idm1, tsm1, to1, addr1, rd1;
    logic busy2, done2, pass2, idm2, tsm2, to2, addr2, rd2;
    logic [31:0] rid1, rts1, rid2, rts2;

    logic        waitreq, rdv;
    logic [31:0] rdata;
    logic        sel, no_resp, stray;
    int          ws_cfg;
    int          ws_cnt = 0;
    logic [31:0] id_val, ts_val, stray_data;
    logic        rdv_q = 1'b0;
    logic [31:0] rdata_q = '0;
    logic        s_rd, s_addr;

    int checks = 0;
    int errors = 0;

    assign s_rd    = sel ? rd2 : rd1;
    assign s_addr  = sel ? addr2 : addr1;
    assign waitreq = s_rd && !s_addr && (ws_cnt < ws_cfg);
    assign rdv     = rdv_q | stray;
    assign rdata   = stray ? stray_data : rdata_q;

    // Slave: address-0 stall of ws_cfg cycles, 1-cycle read latency.
    always @(posedge clock) begin
        ws_cnt  <= (s_rd && waitreq) ? ws_cnt + 1 : 0;
        rdv_q   <= s_rd && !waitreq && !no_resp;
        rdata_q <= s_addr ? ts_val : id_val;
    end

    nios_system_sysid_checker #(
        .CHECK_TIMESTAMP(1), .TIMEOUT_CYCLES(8), .MAX_RETRIES(2), .AUTO_START(1)
    ) dut1 (
        .clock(clock), .reset(reset), .start(start),
        .busy(busy1), .done(done1), .pass(pass1), .id_mismatch(idm1),
        .ts_mismatch(tsm1), .timeout(to1), .read_id(rid1), .read_ts(rts1),
        .avm_address(addr1), .avm_read(rd1), .avm_waitrequest(sel ? 1'b0 : waitreq),
        .avm_readdata(rdata), .avm_readdatavalid(rdv)
    );

    nios_system_sysid_checker #(
        .CHECK_TIMESTAMP(0), .AUTO_START(0)
    ) dut2 (
        .clock(clock), .reset(reset), .start(start2),
        .busy(busy2), .done(done2), .pass(pass2), .id_mismatch(idm2),
        .ts_mismatch(tsm2), .timeout(to2), .read_id(rid2), .read_ts(rts2),
        .avm_address(addr2), .avm_read(rd2), .avm_waitrequest(sel ? waitreq : 1'b0),
        .avm_readdata(rdata), .avm_readdatavalid(rdv)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start1();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input bit which, output int cyc);
        cyc = 0;
        while (!(which ? done2 : done1) && cyc < 200) begin
            tick();
            cyc++;
        end
        if (!(which ? done2 : done1))
            chk("done_wait_bound", 32'd0, 32'd1);
    endtask

    int cyc, bad, strobes, dones, done_at;
    logic prev;

    initial begin
        reset = 1'b1; start = 1'b0; start2 = 1'b0; sel = 1'b0;
        no_resp = 1'b0; stray = 1'b0; ws_cfg = 0;
        id_val = 32'h556C8EB9; ts_val = 32'h0; stray_data = 32'h0;
        repeat (3) tick();
        chk("rst_flags", {busy1, done1, pass1, idm1, tsm1, to1, rd1, addr1}, 32'h0);
        chk("rst_rid", rid1, 32'h0);
        chk("rst_rts", rts1, 32'h0);

        // Auto-start after reset
        reset = 1'b0;
        tick();
        chk("auto_read", {rd1, addr1}, 32'b10);
        wait_done(0, cyc);
        chk("auto_lat", cyc, 32'd5);
        chk("auto_flags", {pass1, idm1, tsm1, to1}, 32'b1000);
        tick();

        // Nominal check, 6-cycle latency
        pulse_start1();
        chk("t1_busy", {busy1, rd1, addr1}, 32'b110);
        wait_done(0, cyc);
        chk("t1_lat", cyc + 1, 32'd6);
        chk("t1_flags", {pass1, idm1, tsm1, to1}, 32'b1000);
        chk("t1_rid", rid1, 32'h556C8EB9);
        chk("t1_rts", rts1, 32'h0);
        tick();
        chk("t1_idle", {busy1, done1}, 32'b00);

        // ID mismatch
        id_val = 32'h12345678;
        pulse_start1();
        wait_done(0, cyc);
        chk("t2_flags", {pass1, idm1, tsm1, to1}, 32'b0100);
        chk("t2_rid", rid1, 32'h12345678);
        tick();
        id_val = 32'h556C8EB9;

        // Timestamp mismatch: enforced on dut1, report-only on dut2
        ts_val = 32'h1;
        pulse_start1();
        wait_done(0, cyc);
        chk("t3_flags1", {pass1, idm1, tsm1, to1}, 32'b0010);
        chk("t3_rts1", rts1, 32'h1);
        tick();
        sel = 1'b1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        wait_done(1, cyc);
        chk("t3_lat2", cyc + 1, 32'd6);
        chk("t3_flags2", {pass2, idm2, tsm2, to2}, 32'b1010);
        chk("t3_rid2", rid2, 32'h556C8EB9);
        tick();
        sel = 1'b0;
        ts_val = 32'h0;

        // Address-0 stall of 5 cycles
        ws_cfg = 5;
        pulse_start1();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if ({rd1, addr1} !== 2'b10) bad++;
            tick();
        end
        chk("t4_hold", bad, 32'd0);
        chk("t4_acc_cyc", {rd1, addr1}, 32'b10);
        tick();
        chk("t4_wait_rd", rd1, 32'd0);
        wait_done(0, cyc);
        chk("t4_lat", cyc + 7, 32'd11);
        chk("t4_flags", {pass1, idm1, tsm1, to1}, 32'b1000);
        ws_cfg = 0;
        tick();

        // No response: 3 strobes, then timeout
        no_resp = 1'b1;
        pulse_start1();
        strobes = 0; dones = 0; done_at = 0; prev = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rd1 && !prev) strobes++;
            prev = rd1;
            if (done1) begin
                dones++;
                done_at = i + 1;
            end
            tick();
        end
        chk("t5_strobes", strobes, 32'd3);
        chk("t5_dones", dones, 32'd1);
        chk("t5_done_cyc", done_at, 32'd25);
        chk("t5_flags", {pass1, idm1, tsm1, to1}, 32'b0001);
        no_resp = 1'b0;

        // Reset in TS_WAIT, then auto rerun
        pulse_start1();
        repeat (3) tick();
        chk("t6_tswait", {busy1, rd1, addr1}, 32'b101);
        reset = 1'b1;
        tick();
        chk("t6_rst_flags", {busy1, done1, pass1, idm1, tsm1, to1, rd1, addr1}, 32'h0);
        chk("t6_rst_rid", rid1, 32'h0);
        chk("t6_rst_rts", rts1, 32'h0);
        reset = 1'b0;
        tick();
        chk("t6_auto_read", {rd1, addr1}, 32'b10);
        wait_done(0, cyc);
        chk("t6_auto_lat", cyc, 32'd5);
        chk("t6_flags", {pass1, idm1, tsm1, to1}, 32'b1000);
        tick();

        // Start while busy / in DONE is dropped; stray valid in IDLE ignored
        pulse_start1();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(0, cyc);
        chk("t7_lat", cyc + 3, 32'd6);
        start = 1'b1;
        tick();
        start = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy1 || rd1 || done1) bad++;
            tick();
        end
        chk("t7_no_rerun", bad, 32'd0);
        stray_data = 32'hDEADBEEF;
        stray = 1'b1;
        tick();
        stray = 1'b0;
        tick();
        chk("t7_rid", rid1, 32'h556C8EB9);
        chk("t7_rts", rts1, 32'h0);
        chk("t7_idle", {busy1, done1, pass1}, 32'b001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
